// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with a 2-flop input synchronizer, optional
// parity, 1 or 2 stop bits and a single-entry valid/ready output holding register.
//
// state   | meaning
// IDLE    | line idle, waiting for rx_s to fall
// START   | half a bit in; confirm the start bit is still low
// DATA    | sampling DATA_BITS data bits mid-bit, LSB first
// PAR     | sampling the parity bit
// STOP    | sampling STOP_BITS stop bits; the last one completes the frame
// WAIT_HI | frame ended on a low stop bit; hold off until the line is high
module uart_rx_param #(
  parameter int HALF_PERIOD = 5,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(2*HALF_PERIOD) + 1;
  // Bit counter needs at least 4 bits so a 9-bit word fits at small HALF_PERIOD.
  localparam int BW = (CW > 4) ? CW : 4;
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(2*HALF_PERIOD - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PAR     = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_m, rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc, perr_acc, ferr_acc;
  logic                 sample, last_data, last_stop, complete;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Sample strobes derived from the down-counter terminal count.
  always_comb begin
    sample    = (cnt == '0) && ((state == START) || (state == DATA) ||
                                (state == PAR)   || (state == STOP));
    last_data = (bit_cnt == LAST_DATA);
    last_stop = (bit_cnt == LAST_STOP);
    complete  = sample && (state == STOP) && last_stop;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (sample) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (sample && last_data) state_nxt = (PARITY != 0) ? PAR : STOP;
      PAR:     if (sample) state_nxt = STOP;
      STOP:    if (complete) state_nxt = rx_s ? IDLE : WAIT_HI;
      WAIT_HI: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing, shift register and per-frame error accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else if ((state == IDLE) && !rx_s) begin
      cnt      <= HALF_LOAD;
      bit_cnt  <= '0;
      par_acc  <= 1'b0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (sample) begin
      cnt <= FULL_LOAD;
      case (state)
        DATA: begin
          shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
          par_acc <= par_acc ^ rx_s;
          bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
        end
        PAR:     perr_acc <= (PARITY == 1) ? ~(par_acc ^ rx_s) : (par_acc ^ rx_s);
        STOP: begin
          ferr_acc <= ferr_acc | ~rx_s;
          bit_cnt  <= bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Output holding register: load on completion unless a held word is unconsumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (!valid || ready) begin
          data       <= shreg;
          parity_err <= perr_acc;
          frame_err  <= ferr_acc | ~rx_s;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: instance A uses defaults, instance B uses even parity and two stop bits.
module tb_uart_rx_param;
  logic       clk, rst;
  logic       rx_a, ready_a, valid_a, perr_a, ferr_a, ovr_a;
  logic [7:0] data_a;
  logic       rx_b, ready_b, valid_b, perr_b, ferr_b, ovr_b;
  logic [7:0] data_b;

  int npass = 0, nchk = 0;
  int cyc = 0;
  int rise_a = 0, nrise_a = 0, nvcyc_a = 0, novr_a = 0;
  int rise_b = 0, nrise_b = 0, novr_b = 0;
  logic       pv_a = 1'b0, pv_b = 1'b0;
  logic [7:0] cap_data_a = '0;
  logic       cap_perr_a = 1'b0, cap_ferr_a = 1'b0;
  int t0, dummy, base0, base1;

  uart_rx_param dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .data(data_a), .valid(valid_a), .ready(ready_a),
    .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a)
  );

  uart_rx_param #(.HALF_PERIOD(5), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .data(data_b), .valid(valid_b), .ready(ready_b),
    .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (valid_a && !pv_a) begin rise_a = cyc; nrise_a++; end
    if (valid_a) begin
      nvcyc_a++;
      cap_data_a = data_a; cap_perr_a = perr_a; cap_ferr_a = ferr_a;
    end
    if (ovr_a) novr_a++;
    pv_a = valid_a;
    if (valid_b && !pv_b) begin rise_b = cyc; nrise_b++; end
    if (ovr_b) novr_b++;
    pv_b = valid_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drives n line bits (bit 0 first), 10 cycles each; t0 is the cycle of the edge before bit 0.
  task automatic drive(input bit sel, input logic [15:0] bits, input int n, output int t);
    @(posedge clk); #2;
    t = cyc;
    for (int i = 0; i < n; i++) begin
      if (sel) rx_b = bits[i];
      else     rx_a = bits[i];
      repeat (10) @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
    repeat (3) @(posedge clk); #2;
    check("rst_valid_a", 32'(valid_a), 0);
    check("rst_data_a",  32'(data_a), 0);
    check("rst_perr_a",  32'(perr_a), 0);
    check("rst_ferr_a",  32'(ferr_a), 0);
    check("rst_ovr_a",   32'(ovr_a), 0);
    check("rst_state_a", 32'(dut_a.state), 0);
    check("rst_rxs_a",   32'(dut_a.rx_s), 1);
    check("rst_valid_b", 32'(valid_b), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk); #2;

    // 0xA5, ready held high: one-cycle valid, 98 cycles after the start edge.
    ready_a = 1'b1;
    base0 = nvcyc_a;
    drive(1'b0, {1'b1, 8'hA5, 1'b0}, 10, t0);
    check("a5_latency", 32'(rise_a - t0), 98);
    check("a5_data",    32'(cap_data_a), 32'hA5);
    check("a5_perr",    32'(cap_perr_a), 0);
    check("a5_ferr",    32'(cap_ferr_a), 0);
    check("a5_vcycles", 32'(nvcyc_a - base0), 1);
    check("a5_valid_lo", 32'(valid_a), 0);

    // Two-cycle low glitch: false start.
    base0 = nrise_a;
    @(posedge clk); #2; rx_a = 1'b0;
    repeat (2) @(posedge clk); #2; rx_a = 1'b1;
    repeat (20) @(posedge clk); #2;
    check("glitch_novalid", 32'(nrise_a - base0), 0);
    check("glitch_idle",    32'(dut_a.state), 0);

    // Overrun: 0x11 held, 0x22 dropped.
    ready_a = 1'b0;
    base0 = novr_a;
    drive(1'b0, {1'b1, 8'h11, 1'b0}, 10, dummy);
    drive(1'b0, {1'b1, 8'h22, 1'b0}, 10, dummy);
    check("ovr_data",  32'(data_a), 32'h11);
    check("ovr_valid", 32'(valid_a), 1);
    check("ovr_pulse", 32'(novr_a - base0), 1);

    // Accept in the completion cycle: new word loads, valid stays high.
    fork
      drive(1'b0, {1'b1, 8'h33, 1'b0}, 10, dummy);
      begin
        @(posedge clk);
        repeat (97) @(posedge clk);
        #2 ready_a = 1'b1;
        @(posedge clk);
        #2 ready_a = 1'b0;
      end
    join
    check("same_cyc_data",  32'(data_a), 32'h33);
    check("same_cyc_valid", 32'(valid_a), 1);
    check("same_cyc_noovr", 32'(novr_a - base0), 1);
    ready_a = 1'b1;
    @(posedge clk); #2;
    check("consume_a", 32'(valid_a), 0);

    // Even parity, 0x07 (three ones): parity bit 0 is an error, 1 is not.
    drive(1'b1, {2'b11, 1'b0, 8'h07, 1'b0}, 12, t0);
    check("par0_latency", 32'(rise_b - t0), 118);
    check("par0_data",    32'(data_b), 32'h07);
    check("par0_perr",    32'(perr_b), 1);
    check("par0_ferr",    32'(ferr_b), 0);
    ready_b = 1'b1; @(posedge clk); #2; ready_b = 1'b0;
    check("consume_b", 32'(valid_b), 0);
    drive(1'b1, {2'b11, 1'b1, 8'h07, 1'b0}, 12, dummy);
    check("par1_valid", 32'(valid_b), 1);
    check("par1_perr",  32'(perr_b), 0);
    ready_b = 1'b1; @(posedge clk); #2; ready_b = 1'b0;

    // Second stop bit low: frame error, park in WAIT_HI while the line is low.
    drive(1'b1, {2'b01, 1'b0, 8'h5A, 1'b0}, 12, dummy);
    repeat (20) @(posedge clk); #2;
    check("stop2_state", 32'(dut_b.state), 5);
    check("stop2_data",  32'(data_b), 32'h5A);
    check("stop2_ferr",  32'(ferr_b), 1);
    check("stop2_perr",  32'(perr_b), 0);
    rx_b = 1'b1;
    repeat (5) @(posedge clk); #2;
    check("stop2_idle", 32'(dut_b.state), 0);
    ready_b = 1'b1; @(posedge clk); #2; ready_b = 1'b0;

    // Break: long low line gives exactly one all-zero frame with frame error.
    base0 = nrise_b; base1 = novr_b;
    @(posedge clk); #2; rx_b = 1'b0;
    repeat (300) @(posedge clk); #2;
    check("break_state", 32'(dut_b.state), 5);
    rx_b = 1'b1;
    repeat (10) @(posedge clk); #2;
    check("break_frames", 32'(nrise_b - base0), 1);
    check("break_data",   32'(data_b), 0);
    check("break_ferr",   32'(ferr_b), 1);
    check("break_perr",   32'(perr_b), 0);
    check("break_noovr",  32'(novr_b - base1), 0);

    // Reset during data bit 3 of instance A; instance B still holds the break word.
    fork
      drive(1'b0, {1'b1, 8'h96, 1'b0}, 10, dummy);
      begin
        @(posedge clk);
        repeat (45) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_data_a",  32'(data_a), 0);
        check("mid_rst_state_a", 32'(dut_a.state), 0);
        check("mid_rst_valid_b", 32'(valid_b), 0);
        check("mid_rst_data_b",  32'(data_b), 0);
        check("mid_rst_ferr_b",  32'(ferr_b), 0);
      end
    join
    rx_a = 1'b1;
    repeat (5) @(posedge clk); #2;
    rst = 1'b0;
    base0 = nrise_a;
    repeat (20) @(posedge clk); #2;
    check("post_rst_novalid", 32'(nrise_a - base0), 0);
    drive(1'b0, {1'b1, 8'h3C, 1'b0}, 10, t0);
    check("post_rst_latency", 32'(rise_a - t0), 98);
    check("post_rst_data",    32'(cap_data_a), 32'h3C);
    check("post_rst_ferr",    32'(cap_ferr_a), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Parameters
REQ-001 The block SHALL have parameter HALF_PERIOD, default 5, giving the clk cycles per half bit (bit period = 2*HALF_PERIOD; legal range >= 2).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame (legal range 5..9).
REQ-003 The block SHALL have parameter PARITY, default 0, selecting parity: 0 = none, 1 = odd, 2 = even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, giving stop bits checked (legal values 1, 2).

Interface
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-007 The block SHALL have port rx, input, 1 bit, the asynchronous serial line (idle high).
REQ-008 The block SHALL have port data, output, DATA_BITS bits, the received word, LSB first on the line.
REQ-009 The block SHALL have port valid, output, 1 bit, high while data and its flags hold an unconsumed word.
REQ-010 The block SHALL have port ready, input, 1 bit, the consumer accept; a transfer occurs on a cycle with valid && ready.
REQ-011 The block SHALL have port parity_err, output, 1 bit, the parity mismatch flag for the word held; always 0 when PARITY = 0.
REQ-012 The block SHALL have port frame_err, output, 1 bit, the flag for the word held: a stop bit was sampled low.
REQ-013 The block SHALL have port overrun, output, 1 bit, a one-cycle pulse when a completed frame is dropped.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; all timing below is relative to rx_s.
REQ-015 States SHALL be IDLE, START, DATA, PAR, STOP, WAIT_HI.
REQ-016 IDLE: on rx_s = 0 -> START, with the bit counter cleared and the cycle counter loaded so the first sample is HALF_PERIOD cycles later.
REQ-017 START sample: rx_s = 1 -> IDLE (false start, nothing output); rx_s = 0 -> DATA.
REQ-018 Each subsequent sample SHALL occur exactly 2*HALF_PERIOD cycles after the previous one (mid-bit).
REQ-019 DATA SHALL shift in DATA_BITS samples LSB first, then go to PAR if PARITY != 0, else to STOP.
REQ-020 PAR: parity_err = (XOR of data bits XOR parity sample) != 0 for even, and == 0 for odd.
REQ-021 STOP SHALL take STOP_BITS samples; frame_err is set if any stop sample = 0.
REQ-022 On the last stop sample the frame completes: the next state is IDLE if that sample = 1, else WAIT_HI.
REQ-023 WAIT_HI SHALL remain until rx_s = 1, then go to IDLE; this blocks re-triggering on a break or low line.
REQ-024 On completion with valid = 0, or valid = 1 && ready = 1 in the same cycle, the block SHALL load data/parity_err/frame_err and set valid the next cycle.
REQ-025 On completion with valid = 1 && ready = 0, the block SHALL drop the new frame, keep the held word unchanged, and pulse overrun for one cycle.
REQ-026 valid SHALL clear on the cycle after a transfer unless a completion is loaded in that same cycle (REQ-024).
REQ-027 data and the flags SHALL remain stable while valid = 1 and no transfer occurs.
REQ-028 Latency SHALL be one cycle from the last stop sample to valid = 1.
REQ-029 Counters SHALL be sized $clog2(2*HALF_PERIOD)+1 bits and SHALL never wrap within a frame.

Reset
REQ-030 rst high SHALL force, asynchronously: state IDLE, counters 0, synchronizer flops 1, valid 0, overrun 0, parity_err 0, frame_err 0, data 0.
REQ-031 rst asserted mid-frame SHALL discard the partial frame; after release, reception resumes only on a new falling edge of rx_s.

Verification
REQ-032 Defaults, ready = 1, send 0xA5 with 1 stop -> valid for one cycle with data = 0xA5, parity_err = 0, frame_err = 0; valid rises 1 cycle after the stop sample.
REQ-033 PARITY = 2, send 0x07 with parity bit 0 -> parity_err = 1; resend with parity bit 1 -> parity_err = 0.
REQ-034 Low glitch on rx shorter than HALF_PERIOD-1 cycles -> no valid, FSM back in IDLE.
REQ-035 STOP_BITS = 2, second stop bit low -> frame_err = 1, FSM in WAIT_HI until rx high; a held-low line (break) produces exactly one frame with data = 0 and frame_err = 1.
REQ-036 ready = 0, send 0x11 then 0x22 -> data stays 0x11, overrun pulses once at completion of 0x22; ready = 1 with a completion in the same cycle -> data = new word, valid stays 1.
REQ-037 rst asserted during DATA bit 3 -> all outputs 0 immediately; a following full frame 0x3C is received correctly.
